spi_master: RTL and testbench

Byte-wide SPI mode-0 shifter that sits directly downstream of the memory controller. It serialises one command/address/data byte per transaction onto the shared flash/RAM SPI bus and returns the byte shifted in on MISO. It also emits single dummy SCK pulses on request. Chip selects are driven by the memory controller, not by this block.

---
 rtl/duck_spi_pkg.sv | 22 ++
 rtl/spi_clk_div.sv | 32 +++
 rtl/spi_master.sv | 135 +++++++++++++
 tb/tb_spi_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_spi_pkg.sv
// Shared definitions for the byte-wide SPI mode-0 master and the memory controller above it.
// The state codes and the read opcode are fixed here so that both sides agree on them.
package duck_spi_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_DUMMY_LO = 3'd3;
  localparam logic [2:0] ST_DUMMY_HI = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_SHIFT_LO = ST_SHIFT_LO,
    S_SHIFT_HI = ST_SHIFT_HI,
    S_DUMMY_LO = ST_DUMMY_LO,
    S_DUMMY_HI = ST_DUMMY_HI
  } spi_state_e;

  localparam int         CLK_DIV_DEFAULT = 2;
  localparam logic [7:0] SPI_OP_READ     = 8'h03;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: pulses tick for one cycle when the count reaches CLK_DIV-1,
// then restarts from zero; clr holds it at zero so every phase starts a full half-period.
module spi_clk_div
  import duck_spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = (clr || tick) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 shifter: sends one byte MSB first on mosi, captures miso on each
// sck rise, and can emit a lone dummy sck pulse. Chip select is owned by the caller.
module spi_master
  import duck_spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_tx,
  output logic [7:0] data_rx,
  input  logic       txn_start,
  output logic       txn_done,
  input  logic       force_clock,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  spi_state_e state_q, state_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic [7:0] data_rx_q, data_rx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       div_clr;
  logic       tick;

  // Held clear while idle so the first low phase after acceptance is a full half-period.
  assign div_clr = (state_q == S_IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = done_q;
    data_rx_d = data_rx_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    unique case (state_q)
      S_IDLE: begin
        if (txn_start) begin
          tx_d      = data_tx[6:0];
          mosi_d    = data_tx[7];
          done_d    = 1'b0;
          bit_cnt_d = 3'd7;
          state_d   = S_SHIFT_LO;
        end else if (force_clock) begin
          done_d  = 1'b0;
          state_d = S_DUMMY_LO;
        end
      end
      S_SHIFT_LO: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], miso};
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt_q != 3'd0) begin
            mosi_d    = tx_q[6];
            tx_d      = {tx_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
            state_d   = S_SHIFT_LO;
          end else begin
            data_rx_d = rx_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DUMMY_LO: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = S_DUMMY_HI;
        end
      end
      S_DUMMY_HI: begin
        if (tick) begin
          sck_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b1;
      data_rx_q <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      data_rx_q <= data_rx_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Shift registers carry data only; their contents are don't-care until a byte is accepted.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign txn_done = done_q;
  assign data_rx  = data_rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a mode-0 slave model feeds miso, a monitor reassembles each
// transaction from the pins and checks it against expectations queued by the stimulus.
module tb_spi_master;
  import duck_spi_pkg::*;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_tx;
  logic [7:0] data_rx;
  logic       txn_start;
  logic       txn_done;
  logic       force_clock;
  logic       sck;
  logic       mosi;
  logic       miso;

  logic [7:0] data_tx1;
  logic [7:0] data_rx1;
  logic       start1;
  logic       done1;
  logic       force1;
  logic       sck1;
  logic       mosi1;
  logic       miso1;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(D)) u_dut (
    .clk (clk), .rst (rst), .data_tx (data_tx), .data_rx (data_rx),
    .txn_start (txn_start), .txn_done (txn_done), .force_clock (force_clock),
    .sck (sck), .mosi (mosi), .miso (miso)
  );

  // Second instance at the fastest divider, with miso looped back from mosi.
  assign miso1 = mosi1;
  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk (clk), .rst (rst), .data_tx (data_tx1), .data_rx (data_rx1),
    .txn_start (start1), .txn_done (done1), .force_clock (force1),
    .sck (sck1), .mosi (mosi1), .miso (miso1)
  );

  typedef struct {
    bit         dummy;
    logic [7:0] tx;
    logic [7:0] rx;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] model_rx;
  logic [7:0] seq_tx[8];
  logic [7:0] seq_rx[8];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Slave: presents the MSB once the transaction starts, then the next bit after each sck fall.
  logic [7:0] s_cur = 8'h00;
  int         s_bit = 0;
  logic       s_prev_done = 1'b1;
  logic       s_prev_sck = 1'b0;
  initial miso = 1'b0;
  always @(negedge clk) begin
    if (s_prev_done && !txn_done) begin
      s_cur = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
      miso  = s_cur[7];
      s_bit = 6;
    end else if (s_prev_sck && !sck && !txn_done && s_bit >= 0) begin
      miso  = s_cur[s_bit];
      s_bit = s_bit - 1;
    end
    s_prev_done = txn_done;
    s_prev_sck  = sck;
  end

  // Monitor
  logic       m_prev_done = 1'b1;
  logic       m_prev_sck = 1'b0;
  logic       m_prev_mosi = 1'b0;
  bit         m_active = 1'b0;
  int         m_low, m_hi, m_rises, m_gap = 1000;
  logic [7:0] m_byte;
  exp_t       m_e;
  always @(negedge clk) begin
    if (rst) begin
      if (m_active && exp_q.size() != 0) m_e = exp_q.pop_front();
      m_active = 1'b0;
      m_gap    = 1000;
    end else begin
      if (mosi !== m_prev_mosi)
        chk("mosi_change_on_fall_or_accept",
            int'((m_prev_sck && !sck) || (m_prev_done && !txn_done)), 1);
      if (m_prev_done && !txn_done) begin
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else if (exp_q[0].gap >= 0) chk("idle_gap", m_gap, exp_q[0].gap);
        m_active = (exp_q.size() != 0);
        m_low = 0; m_hi = 0; m_rises = 0; m_byte = 8'h00;
      end
      if (!txn_done) begin
        m_low++;
        if (sck) m_hi++;
        if (!m_prev_sck && sck) begin
          m_rises++;
          m_byte = {m_byte[6:0], mosi};
        end
      end
      if (!m_prev_done && txn_done && m_active) begin
        m_e = exp_q.pop_front();
        chk("done_low_cycles", m_low, m_e.dummy ? 2 * D : 16 * D);
        chk("sck_rises", m_rises, m_e.dummy ? 1 : 8);
        chk("sck_high_cycles", m_hi, m_e.dummy ? D : 8 * D);
        if (!m_e.dummy) chk("mosi_byte", m_byte, m_e.tx);
        chk("data_rx", data_rx, m_e.rx);
        m_active = 1'b0;
        m_gap    = 1;
      end else if (txn_done) begin
        m_gap++;
      end
    end
    m_prev_done = rst ? 1'b1 : txn_done;
    m_prev_sck  = sck;
    m_prev_mosi = mosi;
  end

  task automatic wait_done();
    int c = 0;
    while (!txn_done && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (!txn_done) chk("done_timeout", 0, 1);
  endtask

  // n bytes with txn_start held throughout; the next byte is presented as soon as done rises.
  task automatic send_seq(input int n, input bit with_force);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      data_tx   = seq_tx[i];
      txn_start = 1'b1;
      if (i == 0) force_clock = with_force;
      e.dummy = 1'b0; e.tx = seq_tx[i]; e.rx = seq_rx[i]; e.gap = (i == 0) ? -1 : 1;
      exp_q.push_back(e);
      resp_q.push_back(seq_rx[i]);
      model_rx = seq_rx[i];
      @(posedge clk); #1;
      force_clock = 1'b0;
      data_tx     = 8'($urandom);
      if (i == n - 1) txn_start = 1'b0;
      wait_done();
    end
  endtask

  task automatic send_dummy();
    exp_t e;
    force_clock = 1'b1;
    e.dummy = 1'b1; e.tx = 8'h00; e.rx = model_rx; e.gap = -1;
    exp_q.push_back(e);
    resp_q.push_back(8'($urandom));
    @(posedge clk); #1;
    force_clock = 1'b0;
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         hi;
    logic [7:0] b;
    logic [7:0] prev;
    rst = 1'b1; txn_start = 1'b0; force_clock = 1'b0; data_tx = 8'h00;
    start1 = 1'b0; force1 = 1'b0; data_tx1 = 8'h00;
    model_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_done", txn_done, 1);
    chk("reset_data_rx", data_rx, 0);
    chk("reset_done1", done1, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    seq_tx[0] = 8'hA5; seq_rx[0] = 8'h3C;
    send_seq(1, 1'b0);
    @(posedge clk); #1;

    seq_tx[0] = SPI_OP_READ; seq_rx[0] = 8'h81;
    seq_tx[1] = 8'h00;       seq_rx[1] = 8'h7E;
    send_seq(2, 1'b0);
    @(posedge clk); #1;

    send_dummy();
    @(posedge clk); #1;

    seq_tx[0] = 8'($urandom); seq_rx[0] = 8'($urandom);
    send_seq(1, 1'b1);
    @(posedge clk); #1;

    seq_tx[0] = SPI_OP_READ; seq_tx[1] = 8'h00; seq_tx[2] = 8'h12;
    seq_tx[3] = 8'h34;       seq_tx[4] = 8'h00;
    for (int i = 0; i < 4; i++) seq_rx[i] = 8'($urandom);
    seq_rx[4] = 8'h5E;
    send_seq(5, 1'b0);
    send_dummy();
    chk("integration_rx", data_rx, 8'h5E);
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      int mode;
      int n;
      mode = int'($urandom_range(0, 2));
      n    = (mode == 1) ? int'($urandom_range(2, 3)) : 1;
      if (mode == 2) begin
        send_dummy();
      end else begin
        for (int i = 0; i < n; i++) begin
          seq_tx[i] = 8'($urandom);
          seq_rx[i] = 8'($urandom);
        end
        send_seq(n, 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Abort mid-transfer
    seq_tx[0] = 8'hC3; seq_rx[0] = 8'h99;
    data_tx = seq_tx[0]; txn_start = 1'b1;
    begin
      exp_t e;
      e.dummy = 1'b0; e.tx = 8'hC3; e.rx = 8'h99; e.gap = -1;
      exp_q.push_back(e);
    end
    resp_q.push_back(8'h99);
    @(posedge clk); #1;
    txn_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_sck", sck, 0);
    chk("abort_done", txn_done, 1);
    chk("abort_data_rx", data_rx, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_data_rx", data_rx, 0);
    seq_tx[0] = 8'h5A; seq_rx[0] = 8'hE7;
    send_seq(1, 1'b0);

    // Fastest divider, loopback byte then a dummy pulse
    b = 8'($urandom);
    data_tx1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; data_tx1 = ~b;
    cyc = 0; hi = 0;
    while (!done1 && cyc < 100) begin
      if (sck1) hi++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("div1_byte_cycles", cyc, 16);
    chk("div1_byte_high", hi, 8);
    chk("div1_loopback_rx", data_rx1, b);
    @(posedge clk); #1;
    prev = data_rx1;
    force1 = 1'b1;
    @(posedge clk); #1;
    force1 = 1'b0;
    cyc = 0; hi = 0;
    while (!done1 && cyc < 100) begin
      if (sck1) hi++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("div1_dummy_cycles", cyc, 2);
    chk("div1_dummy_high", hi, 1);
    chk("div1_dummy_rx", data_rx1, prev);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
